// File: rtl/id_stage.sv
// Instruction-decode / register-read stage feeding the ALU through the ID/EX register.
// Decodes the opcode, reads a bypassed 32x32 register file, detects load-use hazards, handles flush and HALT.
module id_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc4,
  output logic            id_ready,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [5:0]      op,
  output logic [XLEN-1:0] rs,
  output logic [XLEN-1:0] rt,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc4_out_2_ex,
  output logic [XLEN-1:0] i_data_2_ex,
  output logic            ex_valid,
  output logic [4:0]      ex_dst,
  output logic            halted
);

  localparam logic [5:0] OP_LDW  = 6'b001100;
  localparam logic [5:0] OP_HALT = 6'b010001;

  logic [XLEN-1:0] r_rf [NREG];
  logic [5:0]      r_op;
  logic [XLEN-1:0] r_rs, r_rt, r_imm, r_pc4, r_instr;
  logic            r_valid, r_halted;
  logic [4:0]      r_dst;

  logic [5:0]      w_opc;
  logic [4:0]      w_rs_a, w_rt_a, w_rd_a, w_dst;
  logic            w_known, w_use_rs, w_use_rt, w_is_halt;
  logic [XLEN-1:0] w_rs_val, w_rt_val, w_imm;
  logic            w_hazard, w_issue;

  assign w_opc  = if_instr[31:26];
  assign w_rs_a = if_instr[25:21];
  assign w_rt_a = if_instr[20:16];
  assign w_rd_a = if_instr[15:11];
  assign w_imm  = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};

  always_comb begin
    w_known   = 1'b1;
    w_use_rs  = 1'b0;
    w_use_rt  = 1'b0;
    w_dst     = 5'd0;
    w_is_halt = 1'b0;
    case (w_opc)
      6'b000000, 6'b000010, 6'b000100, 6'b000110, 6'b001000, 6'b001010: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
        w_dst    = w_rd_a;
      end
      6'b000001, 6'b000011, 6'b000101, 6'b000111, 6'b001001, 6'b001011, OP_LDW: begin
        w_use_rs = 1'b1;
        w_dst    = w_rt_a;
      end
      6'b001101, 6'b001111: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      6'b001110, 6'b010000: w_use_rs = 1'b1;
      OP_HALT: w_is_halt = 1'b1;
      default: w_known = 1'b0;
    endcase
  end

  // Reads see a same-cycle write-back; R0 is hard-wired to zero.
  always_comb begin
    if (w_rs_a == 5'd0)                    w_rs_val = '0;
    else if (wb_en && (wb_addr == w_rs_a)) w_rs_val = wb_data;
    else                                   w_rs_val = r_rf[w_rs_a];
    if (w_rt_a == 5'd0)                    w_rt_val = '0;
    else if (wb_en && (wb_addr == w_rt_a)) w_rt_val = wb_data;
    else                                   w_rt_val = r_rf[w_rt_a];
  end

  assign w_hazard = if_valid && r_valid && (r_op == OP_LDW) && (r_dst != 5'd0) &&
                    ((w_use_rs && (w_rs_a == r_dst)) || (w_use_rt && (w_rt_a == r_dst)));

  assign id_ready = !r_halted && (flush || !w_hazard);
  assign w_issue  = if_valid && !r_halted && !flush && !w_hazard && w_known;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  // ID/EX pipeline register: a non-issuing cycle always loads an all-zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_op     <= '0;
      r_dst    <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_imm    <= '0;
      r_pc4    <= '0;
      r_instr  <= '0;
      r_halted <= 1'b0;
    end else begin
      if (w_issue) begin
        r_valid <= 1'b1;
        r_op    <= w_opc;
        r_dst   <= w_dst;
        r_rs    <= w_rs_val;
        r_rt    <= w_rt_val;
        r_imm   <= w_imm;
        r_pc4   <= if_pc4;
        r_instr <= if_instr;
      end else begin
        r_valid <= 1'b0;
        r_op    <= '0;
        r_dst   <= '0;
        r_rs    <= '0;
        r_rt    <= '0;
        r_imm   <= '0;
        r_pc4   <= '0;
        r_instr <= '0;
      end
      if (w_issue && w_is_halt) r_halted <= 1'b1;
    end
  end

  assign op           = r_op;
  assign rs           = r_rs;
  assign rt           = r_rt;
  assign imm          = r_imm;
  assign pc4_out_2_ex = r_pc4;
  assign i_data_2_ex  = r_instr;
  assign ex_valid     = r_valid;
  assign ex_dst       = r_dst;
  assign halted       = r_halted;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized traffic against an instruction-level model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, flush, wb_en;
  logic [31:0] if_instr, if_pc4, wb_data;
  logic [4:0]  wb_addr;
  logic        id_ready, ex_valid, halted;
  logic [5:0]  op;
  logic [31:0] rs, rt, imm, pc4_out_2_ex, i_data_2_ex;
  logic [4:0]  ex_dst;

  id_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4),
    .id_ready(id_ready), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .op(op), .rs(rs), .rt(rt), .imm(imm), .pc4_out_2_ex(pc4_out_2_ex), .i_data_2_ex(i_data_2_ex),
    .ex_valid(ex_valid), .ex_dst(ex_dst), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // Architectural model state
  logic [31:0] mreg [32];
  logic        e_valid, e_halted, e_ready;
  logic [5:0]  e_op;
  logic [31:0] e_rs, e_rt, e_imm, e_pc4, e_ins;
  logic [4:0]  e_dst;
  logic        rdy_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("id_ready", {31'd0, id_ready}, {31'd0, e_ready});
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, e_valid});
      chk("op", {26'd0, op}, {26'd0, e_op});
      chk("rs", rs, e_rs);
      chk("rt", rt, e_rt);
      chk("imm", imm, e_imm);
      chk("pc4", pc4_out_2_ex, e_pc4);
      chk("instr", i_data_2_ex, e_ins);
      chk("ex_dst", {27'd0, ex_dst}, {27'd0, e_dst});
      chk("halted", {31'd0, halted}, {31'd0, e_halted});
    end
  end

  // Instruction classes by opcode: which sources are read and where the result goes.
  // dsel: 0 none, 1 rd, 2 rt.  cls: 0 undefined, 1 defined, 2 HALT.
  function automatic void classify(input logic [5:0] o, output int cls, output bit urs,
                                   output bit urt, output int dsel);
    cls = 1; urs = 0; urt = 0; dsel = 0;
    if (o <= 6'd10 && o[0] == 1'b0)      begin urs = 1; urt = 1; dsel = 1; end
    else if (o <= 6'd11 && o[0] == 1'b1) begin urs = 1; dsel = 2; end
    else if (o == 6'd12)                 begin urs = 1; dsel = 2; end
    else if (o == 6'd13 || o == 6'd15)   begin urs = 1; urt = 1; end
    else if (o == 6'd14 || o == 6'd16)   urs = 1;
    else if (o == 6'd17)                 cls = 2;
    else                                 cls = 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    e_valid = 0; e_halted = 0; e_op = 0; e_rs = 0; e_rt = 0;
    e_imm = 0; e_pc4 = 0; e_ins = 0; e_dst = 0; e_ready = 1;
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    int cls, dsel;
    bit urs, urt, hz, iss;
    logic [4:0] a, b;
    logic [31:0] va, vb;
    logic        n_valid;
    logic [5:0]  n_op;
    logic [31:0] n_rs, n_rt, n_imm, n_pc4, n_ins;
    logic [4:0]  n_dst;
    if_valid = v; if_instr = ins; if_pc4 = pc; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    classify(ins[31:26], cls, urs, urt, dsel);
    a = ins[25:21]; b = ins[20:16];
    va = (a == 0) ? 32'd0 : ((we && wa == a) ? wd : mreg[a]);
    vb = (b == 0) ? 32'd0 : ((we && wa == b) ? wd : mreg[b]);
    hz = v && e_valid && e_op == 6'd12 && e_dst != 0 && ((urs && a == e_dst) || (urt && b == e_dst));
    e_ready = e_halted ? 1'b0 : (fl ? 1'b1 : !hz);
    iss = v && !e_halted && !fl && !hz && cls != 0;
    n_valid = iss; n_op = 0; n_rs = 0; n_rt = 0; n_imm = 0; n_pc4 = 0; n_ins = 0; n_dst = 0;
    if (iss) begin
      n_op = ins[31:26]; n_rs = va; n_rt = vb;
      n_imm = 32'($signed(ins[15:0])); n_pc4 = pc; n_ins = ins;
      n_dst = (dsel == 1) ? ins[15:11] : ((dsel == 2) ? b : 5'd0);
    end
    @(posedge clk);
    rdy_s = e_ready;
    #1;
    e_valid = n_valid; e_op = n_op; e_rs = n_rs; e_rt = n_rt; e_imm = n_imm;
    e_pc4 = n_pc4; e_ins = n_ins; e_dst = n_dst;
    if (iss && cls == 2) e_halted = 1;
    if (we && wa != 0) mreg[wa] = wd;
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] o, input logic [4:0] d,
                                        input logic [4:0] s, input logic [4:0] t);
    return {o, s, t, d, 11'd0};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] t,
                                        input logic [4:0] s, input logic [15:0] im);
    return {o, s, t, im};
  endfunction

  initial begin
    logic [31:0] ins;
    logic [5:0]  opc;
    bit          hold;
    rst_n = 0; if_valid = 0; flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    if_instr = 0; if_pc4 = 0;
    model_reset();
    #12;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    rst_n = 1;
    @(posedge clk); #1;
    chk_en = 1;

    // Write-back then read
    step(0, 0, 0, 0, 1, 5'd3, 32'h0000_000A);
    step(0, 0, 0, 0, 1, 5'd4, 32'h0000_0005);
    step(1, rtype(6'b000000, 5, 3, 4), 32'h104, 0, 0, 0, 0);
    chk("wb_op", {26'd0, op}, 32'd0);
    chk("wb_rs", rs, 32'hA);
    chk("wb_rt", rt, 32'h5);
    chk("wb_dst", {27'd0, ex_dst}, 32'd5);
    chk("wb_valid", {31'd0, ex_valid}, 32'd1);

    // Bypass
    step(1, itype(6'b000011, 8, 7, 16'hFFF5), 32'h108, 0, 1, 5'd7, 32'h1234);
    chk("byp_rs", rs, 32'h1234);
    chk("byp_imm", imm, 32'hFFFF_FFF5);
    chk("byp_dst", {27'd0, ex_dst}, 32'd8);

    // Load-use
    step(1, itype(6'b001100, 2, 1, 16'd8), 32'h10C, 0, 0, 0, 0);
    step(1, rtype(6'b001010, 9, 2, 4), 32'h110, 0, 0, 0, 0);
    chk("lu_stall_rdy", {31'd0, rdy_s}, 32'd0);
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    step(1, rtype(6'b001010, 9, 2, 4), 32'h110, 0, 0, 0, 0);
    chk("lu_rdy", {31'd0, rdy_s}, 32'd1);
    chk("lu_op", {26'd0, op}, 32'd10);
    chk("lu_dst", {27'd0, ex_dst}, 32'd9);

    // Flush
    step(1, rtype(6'b000100, 6, 3, 4), 32'h114, 1, 0, 0, 0);
    chk("fl_rdy", {31'd0, rdy_s}, 32'd1);
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_op", {26'd0, op}, 32'd0);

    // R0 and undefined opcode
    step(0, 0, 0, 0, 1, 5'd0, 32'h0000_FFFF);
    step(1, rtype(6'b000000, 1, 0, 0), 32'h118, 0, 0, 0, 0);
    chk("r0_rs", rs, 32'd0);
    chk("r0_rt", rt, 32'd0);
    step(1, {6'b111111, 26'h155}, 32'h11C, 0, 0, 0, 0);
    chk("undef_valid", {31'd0, ex_valid}, 32'd0);

    // Randomized traffic (no HALT)
    hold = 0; ins = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        opc = 6'($urandom_range(0, 16));
        if ($urandom_range(0, 9) == 0) opc = {2'b11, 4'($urandom)};
        ins = {opc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 11'($urandom)};
      end
      step(hold ? 1'b1 : ($urandom_range(0, 99) < 85), ins, $urandom,
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6),
           5'($urandom_range(0, 7)), $urandom);
      hold = !rdy_s;
    end

    // HALT discarded by flush, then issued
    step(1, {6'b010001, 26'd0}, 32'h200, 1, 0, 0, 0);
    chk("halt_fl", {31'd0, halted}, 32'd0);
    step(1, {6'b010001, 26'd0}, 32'h204, 0, 0, 0, 0);
    chk("halt_valid", {31'd0, ex_valid}, 32'd1);
    chk("halt_op", {26'd0, op}, 32'd17);
    chk("halt_set", {31'd0, halted}, 32'd1);
    step(1, rtype(6'b000000, 5, 3, 4), 32'h208, 0, 0, 0, 0);
    chk("halt_rdy", {31'd0, rdy_s}, 32'd0);
    chk("halt_bubble", {31'd0, ex_valid}, 32'd0);
    step(1, {6'b010001, 26'd0}, 32'h20C, 0, 0, 0, 0);
    chk("halt_sticky", {31'd0, halted}, 32'd1);

    // Asynchronous reset between edges
    #2;
    if_valid = 0; flush = 0; wb_en = 0;
    rst_n = 0;
    model_reset();
    #1;
    chk("ar_halted", {31'd0, halted}, 32'd0);
    chk("ar_valid", {31'd0, ex_valid}, 32'd0);
    chk("ar_pc4", pc4_out_2_ex, 32'd0);
    chk("ar_instr", i_data_2_ex, 32'd0);
    @(posedge clk); #3;
    rst_n = 1;
    @(posedge clk); #1;
    chk("ar_rdy", {31'd0, id_ready}, 32'd1);
    step(1, rtype(6'b000000, 5, 3, 7), 32'h300, 0, 0, 0, 0);
    chk("ar_rf_rs", rs, 32'd0);
    chk("ar_rf_rt", rt, 32'd0);
    chk("ar_rf_valid", {31'd0, ex_valid}, 32'd1);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode / register-read stage that sits directly upstream of the ALU. It accepts one fetched instruction per cycle and decodes the 6-bit opcode. It reads two operands from an internal 32x32 register file (with write-back bypass), sign-extends the immediate, and registers everything into the ID/EX pipeline register that drives the ALU's `op`, `rs`, `rt`, `imm`, `pc4_out_2_ex` and `i_data_2_ex` inputs. It also detects load-use hazards, honours branch flushes and latches HALT.

## Interface
- `XLEN`, 32: data, instruction and PC width.
- `NREG`, 32: register count; register address width is 5.
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_valid`  in  1  fetch holds a valid instruction.
- `if_instr`  in  32  instruction word.
- `if_pc4`  in  32  PC+4 of that instruction.
- `id_ready`  out  1  stage accepts `if_instr` this cycle (combinational).
- `flush`  in  1  branch/jump taken in EX; discard the instruction being decoded.
- `wb_en`  in  1  register write-back enable.
- `wb_addr`  in  5  write-back register.
- `wb_data`  in  32  write-back data.
- `op`  out  6  registered opcode to ALU.
- `rs`  out  32  registered source-1 value.
- `rt`  out  32  registered source-2 value.
- `imm`  out  32  registered sign-extended `instr[15:0]`.
- `pc4_out_2_ex`  out  32  registered PC+4.
- `i_data_2_ex`  out  32  registered raw instruction.
- `ex_valid`  out  1  ID/EX register holds a real instruction (0 means bubble).
- `ex_dst`  out  5  destination register; 0 means no write.
- `halted`  out  1  HALT has been issued; sticky until reset.

## Operation
- Instruction fields: opcode `[31:26]`, rs `[25:21]`, rt `[20:16]`, rd `[15:11]`, imm `[15:0]`.
- R-type: ADD 000000, SUB 000010, MUL 000100, OR 000110, AND 001000, XOR 001010.
  - Sources: rs and rt. Destination: rd.
- I-type arithmetic: ADDI 000001, SUBI 000011, MULI 000101, ORI 000111, ANDI 001001, XORI 001011.
  - Source: rs. Destination: rt.
- LDW 001100: source rs, destination rt.
- STW 001101 and BEQ 001111: sources rs and rt, no destination.
- BZ 001110 and JR 010000: source rs, no destination.
- HALT 010001: no sources, no destination.
- Any undefined opcode decodes as a bubble: `ex_valid`=0.
- Register file:
  - R0 reads 0 and writes to it are ignored.
  - Writes occur on the rising edge when `wb_en`=1.
  - Bypass: a same-cycle write to a register being read returns `wb_data`.
- Load-use hazard condition, all of the following:
  - `if_valid`=1;
  - `ex_valid`=1;
  - `op`=LDW;
  - `ex_dst`≠0;
  - `ex_dst` equals a source register the incoming instruction actually uses.
- On a hazard: `id_ready`=0 and a bubble is loaded. Fetch must hold `if_instr`/`if_pc4` stable until `id_ready`=1.
- `flush`=1:
  - next ID/EX contents are a bubble, and the incoming instruction is consumed (`id_ready`=1);
  - flush has priority over the hazard stall;
  - a HALT arriving in the same cycle is discarded and does not set `halted`.
- HALT: issued to EX with `ex_valid`=1, then `halted` is set; afterwards `id_ready`=0 and only bubbles are issued.
- Bubble contents: `ex_valid`=0, `ex_dst`=0, `op`=0, all data outputs 0.

## Timing
- Reset (asynchronous, `rst_n`=0): all registered outputs become 0, `halted`=0 and all registers are 0. `id_ready` is 1 once `rst_n` is released.
- Latency: an instruction accepted at edge N appears on the ID/EX outputs after edge N.
- Throughput: 1 instruction/cycle when there is no hazard.
- A load-use stall lasts exactly 1 cycle; on the next cycle the load has left EX and the hazard condition is false.
- `if_valid`=0 loads a bubble.
- Reset asserted mid-stall or mid-flush clears all state immediately, with no partial update.

## Test plan
- Write-back then read:
  - `wb_en`=1, R3=0x0000000A at edge 1;
  - edge 2 accepts ADD R5,R3,R4 with R4=0x5;
  - after edge 2: `op`=000000, `rs`=0xA, `rt`=0x5, `ex_dst`=5, `ex_valid`=1.
- Bypass:
  - write R7=0x1234 while decoding SUBI R8,R7,0xFFF5 in the same cycle;
  - `rs`=0x1234, `imm`=0xFFFFFFF5, `ex_dst`=8.
- Load-use:
  - LDW R2,8(R1) followed by XOR R9,R2,R4;
  - `id_ready`=0 for 1 cycle, then one bubble (`ex_valid`=0);
  - XOR issues the following cycle.
- Flush:
  - `flush`=1 with MUL on input;
  - next outputs are a bubble, `id_ready`=1, and the MUL never reaches EX.
- R0 and undefined opcodes:
  - write R0=0xFFFF, then ADD R1,R0,R0 gives `rs`=`rt`=0;
  - opcode 111111 gives `ex_valid`=0.
- HALT and reset:
  - HALT issues with `ex_valid`=1, then `halted`=1 and `id_ready`=0;
  - assert `rst_n`=0 asynchronously: all outputs go to 0 before the next edge, and `halted`=0.
